// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: MEM-stage data-memory sequencer.
// Runs one load/store per request, optionally preceded by up to
// MAX_INDIRECT pointer fetches. Drives the data-cache handshake and the
// pipeline stall/done signals. A flush that lands on an unacknowledged
// cache transaction is drained safely before the sequencer goes idle.
module mem_access_sequencer #(
    parameter  int WIDTH        = 16,
    parameter  int MAX_INDIRECT = 1,
    localparam int LANES        = WIDTH / 8,
    localparam int LW           = $clog2(LANES),
    localparam int IW           = $clog2(MAX_INDIRECT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [IW-1:0]    req_indirect,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             flush,
    output logic             mem_read,
    output logic             mem_write,
    output logic [LANES-1:0] mem_wmask,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] rdata,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHAIN = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [IW-1:0] K_MAX = IW'(MAX_INDIRECT);

    // Requested indirection levels above the supported maximum are clamped.
    function automatic logic [IW-1:0] clamp_levels(input logic [IW-1:0] lv);
        if (lv > K_MAX) begin
            return K_MAX;
        end else begin
            return lv;
        end
    endfunction

    // One-hot byte-lane enable for a byte store.
    function automatic logic [LANES-1:0] lane_onehot(input logic [LW-1:0] lane);
        logic [LANES-1:0] m;
        m       = '0;
        m[lane] = 1'b1;
        return m;
    endfunction

    // Zero-extended byte taken from the selected lane of a word.
    function automatic logic [WIDTH-1:0] lane_zext(input logic [WIDTH-1:0] data,
                                                   input logic [LW-1:0]    lane);
        return {{(WIDTH-8){1'b0}}, data[{lane, 3'b000} +: 8]};
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_addr_q, s_addr_d;
    logic [WIDTH-1:0]   s_wdata_q, s_wdata_d;
    logic [LANES-1:0]   s_wmask_q, s_wmask_d;
    logic               s_rd_q, s_rd_d;
    logic               s_wr_q, s_wr_d;

    logic [WIDTH-1:0]   cur_addr_s;
    logic [IW-1:0]      cur_k_s;
    logic               acc_rd_s;
    logic               acc_wr_s;
    logic [LANES-1:0]   acc_wmask_s;
    logic [WIDTH-1:0]   acc_wdata_s;

    // State and datapath registers; reset abandons any op without draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wmask_q <= '0;
            s_rd_q    <= 1'b0;
            s_wr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wmask_q <= s_wmask_d;
            s_rd_q    <= s_rd_d;
            s_wr_q    <= s_wr_d;
        end
    end

    // Shape of the access for the current step (pointer fetch or final op).
    always_comb begin
        cur_addr_s  = '0;
        cur_k_s     = '0;
        acc_rd_s    = 1'b0;
        acc_wr_s    = 1'b0;
        acc_wmask_s = '0;
        acc_wdata_s = '0;
        if (state_q == ST_CHAIN) begin
            cur_addr_s = ptr_q;
            cur_k_s    = cnt_q;
        end else begin
            cur_addr_s = req_addr;
            cur_k_s    = clamp_levels(req_indirect);
        end
        if (cur_k_s != '0) begin
            // Pointer fetch: always a word read, never a write.
            acc_rd_s = 1'b1;
        end else if (req_write) begin
            acc_wr_s = 1'b1;
            if (req_byte) begin
                acc_wmask_s = lane_onehot(cur_addr_s[LW-1:0]);
                acc_wdata_s = {LANES{req_wdata[7:0]}};
            end else begin
                acc_wmask_s = '1;
                acc_wdata_s = req_wdata;
            end
        end else begin
            acc_rd_s = 1'b1;
        end
    end

    // Next-state and cache/pipeline outputs; all outputs held low in reset.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_wmask_d   = s_wmask_q;
        s_rd_d      = s_rd_q;
        s_wr_d      = s_wr_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = '0;
        mem_address = '0;
        mem_wdata   = '0;
        rdata       = '0;
        done        = 1'b0;
        stall       = 1'b0;
        if (!rst_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_CHAIN: begin
                    if (req_valid) begin
                        mem_read    = acc_rd_s;
                        mem_write   = acc_wr_s;
                        mem_wmask   = acc_wmask_s;
                        mem_address = cur_addr_s;
                        mem_wdata   = acc_wdata_s;
                        if (mem_resp) begin
                            if (flush) begin
                                // Transaction finished under flush: drop the op.
                                state_d = ST_IDLE;
                            end else if (cur_k_s != '0) begin
                                ptr_d   = mem_rdata;
                                cnt_d   = cur_k_s - IW'(1);
                                state_d = ST_CHAIN;
                            end else begin
                                done    = 1'b1;
                                state_d = ST_IDLE;
                                if (req_byte) begin
                                    rdata = lane_zext(mem_rdata, cur_addr_s[LW-1:0]);
                                end else begin
                                    rdata = mem_rdata;
                                end
                            end
                        end else if (flush) begin
                            // Cache is mid-transaction: freeze it and finish it out.
                            s_addr_d  = cur_addr_s;
                            s_wdata_d = acc_wdata_s;
                            s_wmask_d = acc_wmask_s;
                            s_rd_d    = acc_rd_s;
                            s_wr_d    = acc_wr_s;
                            state_d   = ST_DRAIN;
                        end else begin
                            state_d = state_q;
                        end
                    end else if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DRAIN: begin
                    mem_read    = s_rd_q;
                    mem_write   = s_wr_q;
                    mem_wmask   = s_wmask_q;
                    mem_address = s_addr_q;
                    mem_wdata   = s_wdata_q;
                    if (mem_resp) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            stall = (req_valid & ~done) | (state_q == ST_DRAIN);
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer (WIDTH=16, MAX_INDIRECT=2).
// A word-addressed memory model answers cache requests; expected access
// sequences, masks and load data are derived from that model.
module tb_mem_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic        req_byte;
    logic [1:0]  req_indirect;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic [15:0] rdata;
    logic        done;
    logic        stall;

    int n_vec;
    int n_err;

    logic [15:0] mem_m [logic [15:0]];

    mem_access_sequencer #(.WIDTH(16), .MAX_INDIRECT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_byte     (req_byte),
        .req_indirect (req_indirect),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .flush        (flush),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .rdata        (rdata),
        .done         (done),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [15:0] a);
        logic [15:0] key;
        key = {a[15:1], 1'b0};
        if (mem_m.exists(key)) return mem_m[key];
        else return key ^ 16'hC3A5;
    endfunction

    task automatic wr_model(input logic [15:0] a, input logic by, input logic [15:0] wd);
        logic [15:0] key;
        logic [15:0] w;
        key = {a[15:1], 1'b0};
        w   = rd_word(a);
        if (!by)      w = wd;
        else if (a[0]) w[15:8] = wd[7:0];
        else          w[7:0] = wd[7:0];
        mem_m[key] = w;
    endtask

    // One cycle with no request: sequencer must be quiet and not stalling.
    task automatic idle_cycle();
        req_valid = 1'b0;
        flush     = 1'b0;
        mem_resp  = 1'b0;
        req_addr  = 16'($urandom);
        mem_rdata = 16'($urandom);
        @(negedge clk);
        check_eq("idle_stall", stall, 1'b0);
        check_eq("idle_read", mem_read, 1'b0);
        check_eq("idle_write", mem_write, 1'b0);
        check_eq("idle_done", done, 1'b0);
        @(posedge clk); #1;
    endtask

    // Full op; per-step wait counts w0..w2 (negative = random 0..2).
    task automatic run_op(input logic wr, input logic by, input logic [1:0] ind,
                          input logic [15:0] addr, input logic [15:0] wd,
                          input int w0, input int w1, input int w2);
        int          k;
        int          w;
        bit          last;
        bit          resp;
        logic [15:0] a;
        logic [15:0] word;
        logic [1:0]  exp_mask;
        logic [15:0] exp_rd;
        k = (ind > 2'd2) ? 2 : int'(ind);
        a = addr;
        req_valid    = 1'b1;
        req_write    = wr;
        req_byte     = by;
        req_indirect = ind;
        req_addr     = addr;
        req_wdata    = wd;
        flush        = 1'b0;
        for (int s = 0; s <= k; s++) begin
            last = (s == k);
            case (s)
                0:       w = w0;
                1:       w = w1;
                default: w = w2;
            endcase
            if (w < 0) w = int'($urandom_range(0, 2));
            for (int c = 0; c <= w; c++) begin
                resp      = (c == w);
                word      = rd_word(a);
                mem_resp  = resp;
                mem_rdata = resp ? word : 16'($urandom);
                exp_mask  = (last && wr) ? (by ? (a[0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
                @(negedge clk);
                check_eq("addr", mem_address, a);
                check_eq("read", mem_read, !(last && wr));
                check_eq("write", mem_write, last && wr);
                check_eq("wmask", mem_wmask, exp_mask);
                check_eq("done", done, last && resp);
                check_eq("stall", stall, !(last && resp));
                if (last && wr)
                    check_eq("wdata", mem_wdata, by ? {wd[7:0], wd[7:0]} : wd);
                if (last && resp && !wr) begin
                    exp_rd = by ? (a[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]}) : word;
                    check_eq("rdata", rdata, exp_rd);
                end
                @(posedge clk); #1;
                if (resp && !last) a = word;
                if (resp && last && wr) wr_model(a, by, wd);
            end
        end
        req_valid = 1'b0;
        mem_resp  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_indirect = 2'd0;
        req_addr = 16'h0; req_wdata = 16'h0; flush = 1'b0;
        mem_resp = 1'b0; mem_rdata = 16'h0;
        mem_m[16'h1000] = 16'hBEEF;
        mem_m[16'h2000] = 16'h3000;
        mem_m[16'h3000] = 16'h1234;
        mem_m[16'h4000] = 16'h0000;
        mem_m[16'h0010] = 16'h0020;
        mem_m[16'h0020] = 16'h0030;

        @(negedge clk);
        check_eq("rst_read", mem_read, 1'b0);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_addr", mem_address, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle();

        // Directed scenarios.
        run_op(1'b0, 1'b0, 2'd0, 16'h1000, 16'h0, 0, 0, 0);        // LD zero-wait
        run_op(1'b0, 1'b0, 2'd1, 16'h2000, 16'h0, 2, 1, 0);        // LDI with waits
        run_op(1'b1, 1'b1, 2'd0, 16'h4001, 16'h00A5, 0, 0, 0);     // STB lane 1
        run_op(1'b0, 1'b1, 2'd0, 16'h4001, 16'h0, 1, 0, 0);        // LDB lane 1
        run_op(1'b1, 1'b0, 2'd2, 16'h0010, 16'h5A5A, 1, 0, 1);     // STI two levels
        check_eq("sti_mem", rd_word(16'h0030), 16'h5A5A);
        run_op(1'b0, 1'b0, 2'd3, 16'h0010, 16'h0, 0, 0, 0);        // clamped to 2
        idle_cycle();

        // Flush on an unacknowledged pointer read: drain at the old address.
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 2'd1;
        req_addr = 16'h2000; flush = 1'b1; mem_resp = 1'b0;
        @(negedge clk);
        check_eq("fa_read", mem_read, 1'b1);
        check_eq("fa_done", done, 1'b0);
        check_eq("fa_stall", stall, 1'b1);
        @(posedge clk); #1;
        req_addr = 16'h6000; req_write = 1'b1; flush = 1'b1;
        @(negedge clk);
        check_eq("drain_addr", mem_address, 16'h2000);
        check_eq("drain_read", mem_read, 1'b1);
        check_eq("drain_write", mem_write, 1'b0);
        check_eq("drain_stall", stall, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h1111;
        @(negedge clk);
        check_eq("drain_addr2", mem_address, 16'h2000);
        check_eq("drain_done", done, 1'b0);
        check_eq("drain_stall2", stall, 1'b1);
        @(posedge clk); #1;
        idle_cycle();

        // Flush on an unacknowledged byte store: snapshot keeps mask and data.
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_indirect = 2'd0;
        req_addr = 16'h4001; req_wdata = 16'h00C3; flush = 1'b1; mem_resp = 1'b0;
        @(negedge clk);
        check_eq("fs_write", mem_write, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0; req_wdata = 16'h0000; req_byte = 1'b0; req_write = 1'b0;
        req_addr = 16'h7777; mem_resp = 1'b1;
        @(negedge clk);
        check_eq("fs_write2", mem_write, 1'b1);
        check_eq("fs_read2", mem_read, 1'b0);
        check_eq("fs_mask", mem_wmask, 2'b10);
        check_eq("fs_wdata", mem_wdata, 16'hC3C3);
        check_eq("fs_addr", mem_address, 16'h4001);
        check_eq("fs_done", done, 1'b0);
        @(posedge clk); #1;
        wr_model(16'h4001, 1'b1, 16'h00C3);
        idle_cycle();

        // Flush coinciding with mem_resp: transaction ends, no done.
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 2'd0;
        req_addr = 16'h1000; flush = 1'b1; mem_resp = 1'b1; mem_rdata = rd_word(16'h1000);
        @(negedge clk);
        check_eq("fr_read", mem_read, 1'b1);
        check_eq("fr_done", done, 1'b0);
        @(posedge clk); #1;
        idle_cycle();

        // Flush in CHAIN with no request: back to IDLE silently.
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 2'd1;
        req_addr = 16'h2000; flush = 1'b0; mem_resp = 1'b1; mem_rdata = rd_word(16'h2000);
        @(negedge clk);
        check_eq("fc_done", done, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b1; mem_resp = 1'b0;
        @(negedge clk);
        check_eq("fc_read", mem_read, 1'b0);
        check_eq("fc_stall", stall, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        run_op(1'b0, 1'b0, 2'd0, 16'h3000, 16'h0, 0, 0, 0);

        // Reset in the middle of a pointer chain.
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 2'd1;
        req_addr = 16'h2000; mem_resp = 1'b1; mem_rdata = rd_word(16'h2000);
        @(negedge clk);
        check_eq("rc_addr0", mem_address, 16'h2000);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        check_eq("rc_chain_addr", mem_address, rd_word(16'h2000));
        #2 rst_n = 1'b0;
        mem_resp = 1'b1; mem_rdata = 16'hFFFF;
        #1;
        check_eq("ar_read", mem_read, 1'b0);
        check_eq("ar_write", mem_write, 1'b0);
        check_eq("ar_wmask", mem_wmask, 2'b00);
        check_eq("ar_addr", mem_address, 16'h0);
        check_eq("ar_wdata", mem_wdata, 16'h0);
        check_eq("ar_done", done, 1'b0);
        check_eq("ar_stall", stall, 1'b0);
        check_eq("ar_rdata", rdata, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_resp = 1'b0;
        run_op(1'b0, 1'b0, 2'd0, 16'h1000, 16'h0, 0, 0, 0);

        // Randomized operations against the memory model.
        for (int i = 0; i < 200; i++) begin
            run_op(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
                   16'($urandom), -1, -1, -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
